// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle between a controlling FSM and
// the bit-serial adder.
//   start, a, b, cin (and sub when SERIAL_ADDER_SUB_EN is defined): request
//   busy, done, sum, cout: status and result
// Modports: master = controller side, slave = adder side.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: one full-adder cell walked across a WIDTH-bit operand pair,
// LSB first, one bit per clock, with a carry flop closing the loop.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - serial_adder_if.slave (start/a/b/cin in, busy/done/sum/cout out)
// Optional: define SERIAL_ADDER_SUB_EN to add bus.sub; sub=1 computes
// (a - b) mod 2^WIDTH with cout=1 meaning no borrow.
// Timing: start accepted at edge E -> done pulse after edge E+WIDTH.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sh_q, sh_d;     // partial sum, filled from the MSB end
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  // Full-adder cell on the current LSBs
  logic s_bit, c_bit;
  assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_bit = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  // Operand load values; subtraction is a + ~b + 1
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = bus.sub ? ~bus.b : bus.b;
  assign c_ld = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_ld = bus.b;
  assign c_ld = bus.cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = b_ld;
          carry_d = c_ld;
          cnt_d   = '0;
          sh_d    = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sh_d    = {s_bit, sh_q[WIDTH-1:1]};
        carry_d = c_bit;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Final bit: publish result on this same edge
          sum_d   = {s_bit, sh_q[WIDTH-1:1]};
          cout_d  = c_bit;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  logic [W-1:0] prev_sum;
  logic         prev_cout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output logic [W-1:0] s, output logic co);
    int unsigned r;
    if (sub) begin
      r  = (int'(a) - int'(b)) & ((1 << W) - 1);
      s  = r[W-1:0];
      co = (a >= b);
    end else begin
      r  = int'(a) + int'(b) + int'(cin);
      s  = r[W-1:0];
      co = r[W];
    end
  endtask

  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    bus.start = st;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sub;
`else
    if (sub) $display("note: sub ignored in add-only build");
`endif
  endtask

  // Waits (from a negedge) for done; returns edges elapsed; checks hold and exclusivity
  task automatic wait_done(input string name, output int k);
    bit held_ok, excl_ok;
    k = 0; held_ok = 1; excl_ok = 1;
    while (!bus.done && k < 20) begin
      if (bus.sum !== prev_sum || bus.cout !== prev_cout) held_ok = 0;
      if (!bus.busy) excl_ok = 0;
      @(negedge clk);
      k++;
    end
    if (bus.busy && bus.done) excl_ok = 0;
    chk({name, " hold"}, 32'(held_ok), 32'd1);
    chk({name, " busy"}, 32'(excl_ok), 32'd1);
    chk({name, " latency"}, k, W);
  endtask

  // Full operation starting at a negedge; ends at the negedge with done high
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       input logic [W-1:0] es, input logic ec);
    int k;
    drive(1'b1, a, b, cin, sub);
    @(negedge clk);
    drive(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    wait_done(name, k);
    chk({name, " sum"}, 32'(bus.sum), 32'(es));
    chk({name, " cout"}, 32'(bus.cout), 32'(ec));
    prev_sum  = es;
    prev_cout = ec;
  endtask

  vec_t tbl[$];

  initial begin
    logic [W-1:0] ra, rb, es;
    logic rc, ec, rs;
    int k, pulses;

    drive(1'b0, '0, '0, 1'b0, 1'b0);
    prev_sum = '0; prev_cout = 1'b0;

    tbl.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0});
    tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    tbl.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
    tbl.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    tbl.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    tbl.push_back('{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1});
    tbl.push_back('{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0});
    tbl.push_back('{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0});
    tbl.push_back('{8'h10, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0});
`endif

    // Reset state
    #12;
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst done", 32'(bus.done), 0);
    chk("rst sum", 32'(bus.sum), 0);
    chk("rst cout", 32'(bus.cout), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, issued back to back (each start lands in the DONE cycle)
    foreach (tbl[i]) do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                           tbl[i].sub, tbl[i].exp_sum, tbl[i].exp_cout);
    @(negedge clk);
    chk("idle after done busy", 32'(bus.busy), 0);
    chk("idle after done done", 32'(bus.done), 0);

    // Random vectors against the model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      model(ra, rb, rc, rs, es, ec);
      do_op($sformatf("rnd%0d", i), ra, rb, rc, rs, es, ec);
      if (i % 3 == 0) @(negedge clk);
    end

    // Start during RUN is ignored
    @(negedge clk);
    drive(1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);                          // after E
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);                          // after E+1
    @(negedge clk);                          // after E+2
    drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);   // sampled at E+3
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) pulses++;
      @(negedge clk);
    end
    chk("ignore pulses", pulses, 1);
    chk("ignore sum", 32'(bus.sum), 32'h96);
    chk("ignore cout", 32'(bus.cout), 0);
    prev_sum = 8'h96; prev_cout = 1'b0;

    // Async reset mid-run
    drive(1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0);
    @(posedge clk);                          // E
    #1 drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);               // E+4
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(bus.busy), 0);
    chk("abort sum", 32'(bus.sum), 0);
    chk("abort cout", 32'(bus.cout), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    chk("abort quiet", pulses, 0);
    prev_sum = '0; prev_cout = 1'b0;
    do_op("after abort", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);
    @(negedge clk);

    // Start held high through DONE
    prev_sum = 8'h02; prev_cout = 1'b0;
    drive(1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);                          // after E
    drive(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
    wait_done("held1", k);
    chk("held1 sum", 32'(bus.sum), 32'h96);
    chk("held1 cout", 32'(bus.cout), 0);
    prev_sum = 8'h96; prev_cout = 1'b0;
    @(negedge clk);                          // after E+9
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("held accepted", 32'(bus.busy), 1);
    wait_done("held2", k);                   // 8 edges after E+9 -> E+17
    chk("held2 sum", 32'(bus.sum), 32'h00);
    chk("held2 cout", 32'(bus.cout), 1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
